// File: rtl/updown_counter_if.sv
// Control/status bundle for updown_counter.
// master drives the controls (clr/load/load_val/en/up), slave is the counter itself.
interface updown_counter_if #(
  parameter int WIDTH = 3
);
  logic             clr;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic             en;
  logic             up;
  logic [WIDTH-1:0] count;
  logic             tc;
  logic             wrap;
  logic             ovf;

  modport master (
    output clr, load, load_val, en, up,
    input  count, tc, wrap, ovf
  );

  modport slave (
    input  clr, load, load_val, en, up,
    output count, tc, wrap, ovf
  );
endinterface

// File: rtl/updown_counter.sv
// Parametrised synchronous up/down modulo counter.
// Features: enable, clipped parallel load, clear, combinational terminal count,
// a one-cycle wrap pulse and a sticky overflow flag.
// Build option UPDOWN_COUNTER_SAT_EN: the count saturates at the range limits
// instead of wrapping. wrap still pulses and ovf is still set on each saturation attempt.
module updown_counter #(
  parameter int              WIDTH  = 3,
  parameter longint unsigned MODULO = 8
) (
  input logic             clk,
  input logic             rst,
  updown_counter_if.slave bus
);

  // Reject out-of-range parameters at elaboration.
  generate
    if (WIDTH < 1 || WIDTH > 32 || MODULO < 2 || MODULO > (64'd1 << WIDTH)) begin : g_bad_param
      $error("updown_counter: illegal WIDTH/MODULO");
    end
  endgenerate

  localparam logic [WIDTH-1:0] MAXV = WIDTH'(MODULO - 64'd1);

  logic [WIDTH-1:0] r_count;
  logic             r_wrap;
  logic             r_ovf;
  logic             w_at_bound;
  logic [WIDTH-1:0] w_load_clip;
  logic [WIDTH-1:0] w_step;
  logic [WIDTH-1:0] w_bound_next;

  // Next step would leave 0..MODULO-1 in the current direction.
  assign w_at_bound   = bus.up ? (r_count == MAXV) : (r_count == '0);
  // Out-of-range load values are clipped to the top of the range.
  assign w_load_clip  = (64'(bus.load_val) < MODULO) ? bus.load_val : MAXV;
  assign w_step       = bus.up ? (r_count + WIDTH'(1)) : (r_count - WIDTH'(1));
`ifdef UPDOWN_COUNTER_SAT_EN
  assign w_bound_next = r_count;
`else
  assign w_bound_next = bus.up ? '0 : MAXV;
`endif

  // Count/flag register. Priority: rst, clr, load, en.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
      r_wrap  <= 1'b0;
      r_ovf   <= 1'b0;
    end else if (bus.clr) begin
      r_count <= '0;
      r_wrap  <= 1'b0;
      r_ovf   <= 1'b0;
    end else if (bus.load) begin
      r_count <= w_load_clip;
      r_wrap  <= 1'b0;
    end else if (bus.en) begin
      if (w_at_bound) begin
        r_count <= w_bound_next;
        r_wrap  <= 1'b1;
        r_ovf   <= 1'b1;
      end else begin
        r_count <= w_step;
        r_wrap  <= 1'b0;
      end
    end else begin
      r_wrap <= 1'b0;
    end
  end

  assign bus.count = r_count;
  assign bus.wrap  = r_wrap;
  assign bus.ovf   = r_ovf;
  // Unregistered so that a cascaded upper stage sees it in the same cycle.
  assign bus.tc    = bus.en & w_at_bound;

endmodule
